model_fetcher: RTL and testbench



---
 rtl/model_fetcher_pkg.sv | 44 ++++
 rtl/model_fetcher.sv | 153 +++++++++++++++
 tb/tb_model_fetcher.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/model_fetcher_pkg.sv
// model_fetcher_pkg: shared payload types for the model buffer read path.
package model_fetcher_pkg;

  localparam int unsigned MF_MAX_MODEL_COUNT    = 10;
  localparam int unsigned MF_MAX_TRIANGLE_COUNT = 512;
  localparam int unsigned MF_INSTANCE_ID_W      = 8;

  localparam int unsigned MODEL_IDX_W = $clog2(MF_MAX_MODEL_COUNT);
  localparam int unsigned TRI_IDX_W   = $clog2(MF_MAX_TRIANGLE_COUNT + 1);
  localparam int unsigned COORD_W     = 32;

  typedef struct packed {
    logic [COORD_W-1:0] v0;
    logic [COORD_W-1:0] v1;
    logic [COORD_W-1:0] v2;
  } triangle_t;

  typedef struct packed {
    logic last;
  } triangle_meta_t;

  typedef struct packed {
    logic [MODEL_IDX_W-1:0] model_index;
    logic [TRI_IDX_W-1:0]   triangle_index;
  } modelbuf_read_t;

  typedef struct packed {
    logic [MODEL_IDX_W-1:0]      model_index;
    logic [MF_INSTANCE_ID_W-1:0] instance_id;
  } fetch_cmd_t;

  typedef struct packed {
    logic                        first;
    logic                        last;
    logic [MF_INSTANCE_ID_W-1:0] instance_id;
  } fetch_meta_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/model_fetcher.sv
// model_fetcher: walks a model's triangles in index order and streams them
// downstream tagged with instance id and first/last flags.
// Optional MODEL_FETCHER_STATS_EN adds saturating triangle/command counters.
module model_fetcher
  import model_fetcher_pkg::*;
#(
  parameter int unsigned MAX_MODEL_COUNT    = MF_MAX_MODEL_COUNT,
  parameter int unsigned MAX_TRIANGLE_COUNT = MF_MAX_TRIANGLE_COUNT,
  parameter int unsigned INSTANCE_ID_W      = MF_INSTANCE_ID_W
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  fetch_cmd_t     cmd_data,
  output logic           req_valid,
  input  logic           req_ready,
  output modelbuf_read_t req_data,
  input  logic           rsp_valid,
  output logic           rsp_ready,
  input  triangle_t      rsp_data,
  input  triangle_meta_t rsp_meta,
  output logic           out_valid,
  input  logic           out_ready,
  output triangle_t      out_data,
  output fetch_meta_t    out_meta,
`ifdef MODEL_FETCHER_STATS_EN
  output logic [31:0]    stat_triangles,
  output logic [15:0]    stat_commands,
`endif
  output logic           done,
  output logic           empty_model
);

  localparam int unsigned MODEL_W = $clog2(MAX_MODEL_COUNT);
  localparam int unsigned TRI_W   = $clog2(MAX_TRIANGLE_COUNT + 1);

  fetch_state_e             state, state_d;
  logic [MODEL_W-1:0]       model_q;
  logic [INSTANCE_ID_W-1:0] inst_q;
  logic [TRI_W-1:0]         tri_idx;

  logic cmd_fire_c, issue_fire_c, step_c, finish_c, empty_c, tri_last_c;

  // A triangle ends the command if the buffer says so or the index cap is hit
  assign tri_last_c = rsp_meta.last | (tri_idx == TRI_W'(MAX_TRIANGLE_COUNT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (cmd_fire_c)   state_d = ST_ISSUE;
      ST_ISSUE: if (issue_fire_c) state_d = ST_WAIT;
      ST_WAIT: begin
        if (finish_c)    state_d = ST_IDLE;
        else if (step_c) state_d = issue_fire_c ? ST_WAIT : ST_ISSUE;
      end
      default:           state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs; WAIT streams the next request alongside each consumed triangle
  always_comb begin
    cmd_ready               = 1'b0;
    req_valid               = 1'b0;
    rsp_ready               = 1'b0;
    out_valid               = 1'b0;
    cmd_fire_c              = 1'b0;
    issue_fire_c            = 1'b0;
    step_c                  = 1'b0;
    finish_c                = 1'b0;
    empty_c                 = 1'b0;
    req_data.model_index    = MODEL_IDX_W'(model_q);
    req_data.triangle_index = TRI_IDX_W'(tri_idx);
    out_data                = rsp_data;
    out_meta.first          = (tri_idx == '0);
    out_meta.last           = tri_last_c;
    out_meta.instance_id    = MF_INSTANCE_ID_W'(inst_q);
    case (state)
      ST_IDLE: begin
        cmd_ready  = 1'b1;
        cmd_fire_c = cmd_valid;
      end
      ST_ISSUE: begin
        req_valid    = 1'b1;
        issue_fire_c = req_ready;
      end
      ST_WAIT: begin
        if (!rsp_valid) begin
          finish_c = 1'b1;
          empty_c  = (tri_idx == '0);
        end else begin
          out_valid = 1'b1;
          rsp_ready = out_ready;
          if (out_ready) begin
            if (tri_last_c) begin
              finish_c = 1'b1;
            end else begin
              step_c                  = 1'b1;
              req_valid               = 1'b1;
              req_data.triangle_index = TRI_IDX_W'(tri_idx + TRI_W'(1));
              issue_fire_c            = req_ready;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Command latches, triangle index and completion pulses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      model_q     <= '0;
      inst_q      <= '0;
      tri_idx     <= '0;
      done        <= 1'b0;
      empty_model <= 1'b0;
    end else begin
      done        <= finish_c;
      empty_model <= empty_c;
      if (cmd_fire_c) begin
        model_q <= MODEL_W'(cmd_data.model_index);
        inst_q  <= INSTANCE_ID_W'(cmd_data.instance_id);
        tri_idx <= '0;
      end else if (step_c) begin
        tri_idx <= tri_idx + TRI_W'(1);
      end
    end
  end

`ifdef MODEL_FETCHER_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_triangles <= '0;
      stat_commands  <= '0;
    end else begin
      if (out_valid && out_ready && (stat_triangles != '1))
        stat_triangles <= stat_triangles + 32'd1;
      if (done && (stat_commands != '1))
        stat_commands <= stat_commands + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_model_fetcher.sv
// tb_model_fetcher: directed bench with a small behavioural model buffer.
module tb_model_fetcher;
  import model_fetcher_pkg::*;

  localparam int unsigned MTC = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic           cmd_valid;
  logic           cmd_ready;
  fetch_cmd_t     cmd_data;
  logic           req_valid;
  logic           req_ready;
  modelbuf_read_t req_data;
  logic           rsp_valid;
  logic           rsp_ready;
  triangle_t      rsp_data;
  triangle_meta_t rsp_meta;
  logic           out_valid;
  logic           out_ready;
  triangle_t      out_data;
  fetch_meta_t    out_meta;
  logic           done;
  logic           empty_model;
`ifdef MODEL_FETCHER_STATS_EN
  logic [31:0]    stat_triangles;
  logic [15:0]    stat_commands;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  model_fetcher #(
    .MAX_MODEL_COUNT(10),
    .MAX_TRIANGLE_COUNT(MTC),
    .INSTANCE_ID_W(8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_meta(rsp_meta),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_meta(out_meta),
`ifdef MODEL_FETCHER_STATS_EN
    .stat_triangles(stat_triangles), .stat_commands(stat_commands),
`endif
    .done(done), .empty_model(empty_model)
  );

  // Model buffer: sizes per slot, response one cycle after acceptance
  logic                   pend = 1'b0;
  logic [MODEL_IDX_W-1:0] b_model = '0;
  logic [TRI_IDX_W-1:0]   b_idx = '0;
  logic                   use_last = 1'b1;

  function automatic int unsigned msize(input logic [MODEL_IDX_W-1:0] m);
    case (m)
      4'd2:    return 3;
      4'd3:    return 4;
      4'd7:    return 6;
      default: return 0;
    endcase
  endfunction

  function automatic triangle_t tri_of(input int unsigned m, input int unsigned i);
    triangle_t t;
    t.v0 = 32'hA000_0000 | (m << 8) | i;
    t.v1 = 32'h5000_0000 + i * 3;
    t.v2 = ~(m * 32'h0101_0101 + i);
    return t;
  endfunction

  always @(posedge clk) begin
    if (!rstn) pend <= 1'b0;
    else if (req_valid && req_ready) begin
      pend    <= (32'(req_data.triangle_index) < msize(req_data.model_index));
      b_model <= req_data.model_index;
      b_idx   <= req_data.triangle_index;
    end else if (rsp_valid && rsp_ready) pend <= 1'b0;
  end

  assign rsp_valid = pend;
  assign rsp_data  = tri_of(32'(b_model), 32'(b_idx));
  always_comb rsp_meta.last = use_last && ((32'(b_idx) + 1) == msize(b_model));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int unsigned m, input int unsigned id);
    cmd_valid            = 1'b1;
    cmd_data.model_index = MODEL_IDX_W'(m);
    cmd_data.instance_id = MF_INSTANCE_ID_W'(id);
  endtask

  task automatic expect_req(input string tag, input int unsigned m, input int unsigned i);
    modelbuf_read_t e;
    e.model_index    = MODEL_IDX_W'(m);
    e.triangle_index = TRI_IDX_W'(i);
    chk1({tag, "_valid"}, req_valid, 1'b1);
    chkw({tag, "_data"}, 128'(req_data), 128'(e));
  endtask

  task automatic expect_out(input string tag, input int unsigned m, input int unsigned i,
                            input logic f, input logic l, input int unsigned id);
    fetch_meta_t e;
    e.first       = f;
    e.last        = l;
    e.instance_id = MF_INSTANCE_ID_W'(id);
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chkw({tag, "_data"}, 128'(out_data), 128'(tri_of(m, i)));
    chkw({tag, "_meta"}, 128'(out_meta), 128'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    req_ready = 1'b1;
    out_ready = 1'b1;
    tick();
    mid();
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    chk1("rst_req_valid", req_valid, 1'b0);
    chk1("rst_rsp_ready", rsp_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_empty", empty_model, 1'b0);
    tick();
    rstn = 1'b1;

    // Three-triangle model, no backpressure
    send(2, 8'h11);
    mid(); chk1("t1_cmd_ready", cmd_ready, 1'b1); tick();
    cmd_valid = 1'b0;
    mid(); expect_req("t1_req0", 2, 0); chk1("t1_busy", cmd_ready, 1'b0);
    chk1("t1_no_out", out_valid, 1'b0); tick();
    mid(); expect_out("t1_T0", 2, 0, 1'b1, 1'b0, 8'h11); expect_req("t1_req1", 2, 1); tick();
    mid(); expect_out("t1_T1", 2, 1, 1'b0, 1'b0, 8'h11); expect_req("t1_req2", 2, 2); tick();
    mid(); expect_out("t1_T2", 2, 2, 1'b0, 1'b1, 8'h11); chk1("t1_no_req3", req_valid, 1'b0);
    chk1("t1_done_early", done, 1'b0); tick();
    mid(); chk1("t1_done", done, 1'b1); chk1("t1_empty", empty_model, 1'b0);
    chk1("t1_idle_ready", cmd_ready, 1'b1); chk1("t1_out_off", out_valid, 1'b0); tick();
    mid(); chk1("t1_done_pulse", done, 1'b0); tick();

    // Empty model
    send(5, 8'h22); tick();
    cmd_valid = 1'b0;
    mid(); expect_req("t2_req0", 5, 0); tick();
    mid(); chk1("t2_no_out", out_valid, 1'b0); chk1("t2_no_req", req_valid, 1'b0);
    chk1("t2_done_early", done, 1'b0); tick();
    mid(); chk1("t2_done", done, 1'b1); chk1("t2_empty", empty_model, 1'b1);
    chk1("t2_idle", cmd_ready, 1'b1); tick();
    mid(); chk1("t2_done_pulse", done, 1'b0); chk1("t2_empty_pulse", empty_model, 1'b0); tick();

    // Downstream stall on T1
    send(3, 8'h33); tick();
    cmd_valid = 1'b0;
    mid(); expect_req("t3_req0", 3, 0); tick();
    mid(); expect_out("t3_T0", 3, 0, 1'b1, 1'b0, 8'h33); expect_req("t3_req1", 3, 1); tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mid(); expect_out("t3_hold", 3, 1, 1'b0, 1'b0, 8'h33);
      chk1("t3_hold_noreq", req_valid, 1'b0); chk1("t3_hold_rsp_ready", rsp_ready, 1'b0); tick();
    end
    out_ready = 1'b1;
    mid(); expect_out("t3_T1", 3, 1, 1'b0, 1'b0, 8'h33); expect_req("t3_req2", 3, 2); tick();
    mid(); expect_out("t3_T2", 3, 2, 1'b0, 1'b0, 8'h33); expect_req("t3_req3", 3, 3); tick();
    mid(); expect_out("t3_T3", 3, 3, 1'b0, 1'b1, 8'h33); chk1("t3_no_req4", req_valid, 1'b0); tick();
    mid(); chk1("t3_done", done, 1'b1); chk1("t3_out_off", out_valid, 1'b0); tick();

    // Request stall in ISSUE while a second command is offered
    send(2, 8'h44); tick();
    send(7, 8'h99);
    req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid(); expect_req("t4_stall", 2, 0); chk1("t4_no_out", out_valid, 1'b0);
      chk1("t4_no_cmd", cmd_ready, 1'b0); tick();
    end
    cmd_valid = 1'b0;
    req_ready = 1'b1;
    mid(); expect_req("t4_req0", 2, 0); tick();
    mid(); expect_out("t4_T0", 2, 0, 1'b1, 1'b0, 8'h44); tick();
    mid(); expect_out("t4_T1", 2, 1, 1'b0, 1'b0, 8'h44); tick();
    mid(); expect_out("t4_T2", 2, 2, 1'b0, 1'b1, 8'h44); tick();
    mid(); chk1("t4_done", done, 1'b1); tick();

    // Reset mid-stream, then a fresh command
    send(3, 8'h55); tick();
    cmd_valid = 1'b0;
    mid(); tick();
    mid(); expect_out("t5_T0", 3, 0, 1'b1, 1'b0, 8'h55); tick();
    mid(); expect_out("t5_T1", 3, 1, 1'b0, 1'b0, 8'h55); tick();
    rstn = 1'b0;
    mid(); tick();
    rstn = 1'b1;
    send(2, 8'h66);
    mid(); chk1("t5_out_valid", out_valid, 1'b0); chk1("t5_req_valid", req_valid, 1'b0);
    chk1("t5_rsp_ready", rsp_ready, 1'b0); chk1("t5_cmd_ready", cmd_ready, 1'b1);
    chk1("t5_done", done, 1'b0); tick();
    cmd_valid = 1'b0;
    mid(); expect_req("t5_req0", 2, 0); tick();
    mid(); expect_out("t5_new_T0", 2, 0, 1'b1, 1'b0, 8'h66); tick();
    mid(); tick();
    mid(); expect_out("t5_new_T2", 2, 2, 1'b0, 1'b1, 8'h66); tick();
    mid(); chk1("t5_new_done", done, 1'b1); tick();

    // Buffer never flags last: index cap forces it
    use_last = 1'b0;
    send(7, 8'h77); tick();
    cmd_valid = 1'b0;
    mid(); expect_req("t6_req0", 7, 0); tick();
    for (int k = 0; k < 4; k++) begin
      mid(); expect_out("t6_T", 7, k, (k == 0), (k == 3), 8'h77);
      if (k < 3) expect_req("t6_req", 7, k + 1);
      else       chk1("t6_no_req4", req_valid, 1'b0);
      tick();
    end
    mid(); chk1("t6_done", done, 1'b1); chk1("t6_empty", empty_model, 1'b0);
    chk1("t6_no_req", req_valid, 1'b0); tick();
    mid(); chk1("t6_idle_noreq", req_valid, 1'b0); chk1("t6_done_pulse", done, 1'b0); tick();
    use_last = 1'b1;

`ifdef MODEL_FETCHER_STATS_EN
    chkw("stat_triangles", 128'(stat_triangles), 128'(7));
    chkw("stat_commands", 128'(stat_commands), 128'(2));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
